// File: rtl/rf_arbiter_pkg.sv
// rf_arb_pkg: shared FSM state type, default sizes and small helpers
// for the register-file arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int RF_ADDR_W     = 5;
  localparam int RF_DATA_W     = 16;
  localparam int ARB_MAX_BURST = 4;

  // Width of a requester index; never zero so a single requester still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if: requester-side bus of the register-file arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface rf_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rf_arbiter_rr_pick.sv
// rr_pick: combinational winner search. Starting at index ptr and wrapping
// around, the first requesting index wins. A ptr tied to zero gives fixed
// lowest-index priority.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Walk offsets 0..N_REQ-1 from ptr and latch the first active request.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_valid && req[j] && (j == ((int'(ptr) + i) % N_REQ))) begin
          win_valid  = 1'b1;
          win_idx    = IDX_W'(j);
          win_oh[j]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: shares one register-file write/read port between N_REQ
// requesters with registered one-hot grants and optional locked bursts.
// Build option: define RF_ARBITER_FIXED_PRIO_EN for fixed lowest-index
// priority instead of round-robin (no rotating pointer is built then).
module rf_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  rf_arbiter_if.slave       bus,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int IDX_W   = idx_width(N_REQ);
  localparam int BURST_W = 4;

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [IDX_W-1:0]   search_ptr;
  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               take_pick;
  logic               fire;
  logic               rd_fire;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (bus.req),
    .ptr       (search_ptr),
    .win_oh    (pick_oh),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

`ifdef RF_ARBITER_FIXED_PRIO_EN
  assign search_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer moves to the slot after each newly picked winner.
  always_comb begin
    ptr_d = ptr_q;
    if (take_pick) begin
      ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign search_ptr = ptr_q;
`endif

  // Next-state logic: extend a locked burst, hand over, re-grant or go idle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    burst_d   = burst_q;
    take_pick = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        burst_d = '0;
        if (pick_valid) begin
          state_d   = GRANT;
          gnt_d     = pick_oh;
          win_d     = pick_idx;
          take_pick = 1'b1;
        end
      end
      GRANT, HOLD: begin
        if (bus.req[win_q] && bus.lock[win_q] &&
            (burst_q < BURST_W'(MAX_BURST - 1))) begin
          state_d = HOLD;
          burst_d = burst_q + 1'b1;
        end else if (pick_valid) begin
          state_d   = GRANT;
          gnt_d     = pick_oh;
          win_d     = pick_idx;
          burst_d   = '0;
          take_pick = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    endcase
  end

  assign fire = |(gnt_q & bus.req);

  // Drive the register-file port only while the granted requester still asks.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = '0;
    rd_fire  = 1'b0;
    if (fire) begin
      if (bus.we[win_q]) begin
        rf_we    = 1'b1;
        rf_waddr = bus.addr[win_q*ADDR_W +: ADDR_W];
        rf_wdata = bus.wdata[win_q*DATA_W +: DATA_W];
      end else begin
        rf_raddr = bus.addr[win_q*ADDR_W +: ADDR_W];
        rd_fire  = 1'b1;
      end
    end
  end

  // Capture read data one cycle after the read and pulse the owner's rvalid.
  always_comb begin
    rvalid_d = rd_fire ? gnt_q : '0;
    rdata_d  = rd_fire ? rf_rdata : rdata_q;
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      win_q    <= '0;
      burst_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      win_q    <= win_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed bench for rf_arbiter with a small register-file
// model; expected values are hand-computed per step.
module tb_rf_arbiter;
  import rf_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] rf_mem [32];

  int errorCount = 0;
  int checkCount = 0;

  rf_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rf_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  // Register-file model: known contents on reset, synchronous write port.
  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= DW'(16'h1000 + i);
      rf_mem[7] <= 16'h1234;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] w);
    bus.req  = r;
    bus.lock = l;
    bus.we   = w;
    #1;
  endtask

  task automatic setPort(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence; every expected value below is worked out by hand.
  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.we   = '0;
    bus.addr = '0;
    bus.wdata = '0;
    tick();
    tick();
    checkOutput("reset_gnt", bus.gnt, 0);
    checkOutput("reset_rvalid", bus.rvalid, 0);
    checkOutput("reset_rdata", bus.rdata, 0);
    checkOutput("reset_rf_we", rf_we, 0);
    rst = 1'b0;

    // Single read of RF[7] by requester 2.
    setPort(2, 5'd7, 16'h0);
    applyStimulus(3'b100, 3'b000, 3'b000);
    tick();
    checkOutput("rd_gnt", bus.gnt, 3'b100);
    checkOutput("rd_raddr", rf_raddr, 7);
    checkOutput("rd_we", rf_we, 0);
    checkOutput("rd_rvalid_early", bus.rvalid, 0);
    tick();
    checkOutput("rd_rvalid", bus.rvalid, 3'b100);
    checkOutput("rd_rdata", bus.rdata, 16'h1234);
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkOutput("rd_raddr_idle", rf_raddr, 0);
    tick();
    checkOutput("rd_gnt_idle", bus.gnt, 0);
    checkOutput("rd_rvalid_idle", bus.rvalid, 0);
    checkOutput("rd_rdata_hold", bus.rdata, 16'h1234);

    // Round-robin among all three readers, pointer starts at 0.
    setPort(0, 5'd1, 16'h0);
    setPort(1, 5'd2, 16'h0);
    setPort(2, 5'd3, 16'h0);
    applyStimulus(3'b111, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("rr_gnt_%0d", k), bus.gnt, 3'b001 << (k % 3));
      if (k > 0) begin
        checkOutput($sformatf("rr_rvalid_%0d", k), bus.rvalid, 3'b001 << ((k - 1) % 3));
        checkOutput($sformatf("rr_rdata_%0d", k), bus.rdata, 16'h1001 + ((k - 1) % 3));
      end
    end
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    checkOutput("rr_gnt_end", bus.gnt, 0);
    checkOutput("rr_rvalid_end", bus.rvalid, 0);

    // Write 0xBEEF to RF[9] through requester 1.
    setPort(1, 5'd9, 16'hBEEF);
    applyStimulus(3'b010, 3'b000, 3'b010);
    tick();
    checkOutput("wr_gnt", bus.gnt, 3'b010);
    checkOutput("wr_we", rf_we, 1);
    checkOutput("wr_waddr", rf_waddr, 9);
    checkOutput("wr_wdata", rf_wdata, 16'hBEEF);
    tick();
    checkOutput("wr_rvalid", bus.rvalid, 0);
    applyStimulus(3'b000, 3'b000, 3'b010);
    checkOutput("wr_we_dropped", rf_we, 0);
    tick();
    checkOutput("wr_gnt_end", bus.gnt, 0);

    // Requester 1 drops its write request during its grant cycle.
    setPort(1, 5'd9, 16'h5555);
    applyStimulus(3'b010, 3'b000, 3'b010);
    tick();
    checkOutput("drop_gnt", bus.gnt, 3'b010);
    applyStimulus(3'b000, 3'b000, 3'b010);
    checkOutput("drop_we", rf_we, 0);
    checkOutput("drop_waddr", rf_waddr, 0);
    checkOutput("drop_wdata", rf_wdata, 0);
    tick();
    checkOutput("drop_gnt_idle", bus.gnt, 0);
    checkOutput("drop_rvalid", bus.rvalid, 0);

    // Read back RF[9] through requester 0: the dropped write must not land.
    setPort(0, 5'd9, 16'h0);
    applyStimulus(3'b001, 3'b000, 3'b000);
    tick();
    checkOutput("rb_gnt", bus.gnt, 3'b001);
    tick();
    checkOutput("rb_rvalid", bus.rvalid, 3'b001);
    checkOutput("rb_rdata", bus.rdata, 16'hBEEF);
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();

    // Burst limit: requester 0 locks while requester 1 waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("burst_reset_rdata", bus.rdata, 0);
    setPort(0, 5'd4, 16'h0);
    setPort(1, 5'd5, 16'h0);
    applyStimulus(3'b011, 3'b001, 3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("burst_gnt0_%0d", k), bus.gnt, 3'b001);
    end
    tick();
    checkOutput("burst_gnt1", bus.gnt, 3'b010);
    checkOutput("burst_rvalid0", bus.rvalid, 3'b001);
    checkOutput("burst_rdata0", bus.rdata, 16'h1004);
    tick();
    checkOutput("burst_gnt0_again", bus.gnt, 3'b001);
    checkOutput("burst_rvalid1", bus.rvalid, 3'b010);
    checkOutput("burst_rdata1", bus.rdata, 16'h1005);
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    checkOutput("burst_gnt_end", bus.gnt, 0);

    // Reset asserted in the grant cycle of a read.
    setPort(2, 5'd7, 16'h0);
    applyStimulus(3'b100, 3'b000, 3'b000);
    tick();
    checkOutput("mrst_gnt", bus.gnt, 3'b100);
    rst = 1'b1;
    tick();
    checkOutput("mrst_rvalid", bus.rvalid, 0);
    checkOutput("mrst_gnt_cleared", bus.gnt, 0);
    checkOutput("mrst_rdata", bus.rdata, 0);
    rst = 1'b0;
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    checkOutput("mrst_rvalid_after", bus.rvalid, 0);
    checkOutput("mrst_gnt_after", bus.gnt, 0);

    // Requesters 1 and 2 held together.
    applyStimulus(3'b110, 3'b000, 3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef RF_ARBITER_FIXED_PRIO_EN
      checkOutput($sformatf("prio_gnt_%0d", k), bus.gnt, 3'b010);
`else
      checkOutput($sformatf("prio_gnt_%0d", k), bus.gnt, (k % 2 == 0) ? 3'b010 : 3'b100);
`endif
    end
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    checkOutput("final_gnt", bus.gnt, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (0 = ALU sequencer, 1 = LFSR loader, 2 = display scanner).
REQ-002 Parameter ADDR_W, default 5: register-file address width.
REQ-003 Parameter DATA_W, default 16: register-file data width.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive locked grants to one requester, legal range 1..15.
REQ-005 Port: clk  in  1  single clock; all state on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: req  in  N_REQ  per-requester access request.
REQ-008 Port: lock  in  N_REQ  per-requester burst hold request.
REQ-009 Port: we  in  N_REQ  per-requester write (1) / read (0) select.
REQ-010 Port: addr  in  N_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
REQ-011 Port: wdata  in  N_REQ*DATA_W  per-requester write data.
REQ-012 Port: gnt  out  N_REQ  registered one-hot grant.
REQ-013 Port: rvalid  out  N_REQ  read-data-valid strobe per requester.
REQ-014 Port: rdata  out  DATA_W  registered read data, shared by all requesters.
REQ-015 Port: rf_we, rf_waddr, rf_wdata, rf_raddr  out  1/ADDR_W/DATA_W/ADDR_W  register-file write and read port.
REQ-016 Port: rf_rdata  in  DATA_W  register-file combinational read data.

Function
REQ-017 FSM states: IDLE, GRANT, HOLD; the one-hot grant and the winner index are registered.
REQ-018 IDLE: if any req is high, select a winner, move to GRANT, and assert gnt[winner] on the next cycle. Otherwise stay in IDLE with gnt=0.
REQ-019 Winner selection: round-robin. Search starts at the index after the last winner, modulo N_REQ. The search pointer is 0 after reset.
REQ-020 GRANT or HOLD, when req[w] & lock[w] is high and burst_cnt < MAX_BURST-1: go to HOLD, keep gnt[w], and increment burst_cnt.
REQ-021 Otherwise, if another req is pending: go to GRANT with a new round-robin winner, and reset burst_cnt to 0.
REQ-022 Otherwise, if req[w] alone is still high: re-grant w in GRANT and reset burst_cnt to 0.
REQ-023 Otherwise: go to IDLE.
REQ-024 Access fires only in a cycle where gnt[i] & req[i] is high. A dropped req during grant produces no access.
REQ-025 Write access: rf_we=1, rf_waddr=addr[i], rf_wdata=wdata[i], all combinational in the grant cycle.
REQ-026 Read access: rf_raddr=addr[i]. On the next edge, rdata<=rf_rdata and rvalid[i] pulses high for exactly one cycle. Read latency from grant is 1 cycle.
REQ-027 When no access fires: rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0. rdata holds its last value.
REQ-028 At most one bit of gnt and at most one bit of rvalid is high in any cycle.
REQ-029 Simultaneous requests from all N_REQ requesters are each served within N_REQ*MAX_BURST cycles (starvation bound).
REQ-030 burst_cnt saturates at MAX_BURST-1 and never wraps.
REQ-031 An out-of-range address is impossible by construction (ADDR_W bits). No checking is required.

Reset
REQ-032 While rst is high at a clock edge: state=IDLE, gnt=0, rvalid=0, rdata=0, burst_cnt=0, rr pointer=0.
REQ-033 Reset mid-burst discards the in-flight read; rvalid stays 0 on the following cycle.

Configuration
REQ-034 Macro RF_ARBITER_FIXED_PRIO_EN defined: winner selection is fixed priority, with the lowest index winning. The round-robin pointer is not implemented, and the REQ-029 bound does not apply.
REQ-035 Macro RF_ARBITER_FIXED_PRIO_EN undefined: winner selection is round-robin as in REQ-019.

Structure
REQ-036 Package rf_arb_pkg SHALL hold the state enum (arb_state_t) and the default constants RF_ADDR_W=5, RF_DATA_W=16, and ARB_MAX_BURST=4.
REQ-037 Winner selection SHALL be a sub-module, rr_pick: combinational request vector + pointer -> one-hot winner + index.

Verification
REQ-038 Single read: reset, then req[2]=1, we[2]=0, addr[2]=7, with RF[7]=0x1234. Required: gnt[2] one cycle later; rvalid[2]=1 and rdata=0x1234 on the following cycle.
REQ-039 Round-robin: req=3'b111 held, lock=0. Required: grant order 0,1,2,0,1,2, with one cycle per grant.
REQ-040 Burst limit: req[0]=lock[0]=1 and req[1]=1 held, MAX_BURST=4. Required: gnt[0] for 4 consecutive cycles, then gnt[1].
REQ-041 Dropped request: requester 1 is granted, then req[1]=0 in the grant cycle. Required: rf_we=0 and no rvalid[1]; FSM returns to IDLE.
REQ-042 Reset mid-read: rst=1 in the cycle after a read grant. Required: rvalid=0, gnt=0, rdata=0 on the next cycle.
REQ-043 Fixed priority: with RF_ARBITER_FIXED_PRIO_EN defined, hold req=3'b110. Required: gnt[1] is granted every cycle and req[2] is never served.
